lsram_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller that sequences the LSRAM top (non-pipelined sync read).

---
 rtl/lsram_fifo_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsram_fifo_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsram_fifo_ctrl.sv
// lsram_fifo_ctrl: pointer/count/flag sequencer for a single-clock FIFO built on a sync-read LSRAM.
// Latency: RAM strobes are combinational from the registered flags; DVLD trails an accepted read by RD_LATENCY.
// Backpressure: none on read data; a write while FULL or a read while EMPTY is rejected and flagged.
// Optional: define LSRAM_FIFO_CTRL_ECC_EN to add SB/DB error monitoring of read data.
module lsram_fifo_ctrl #(
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 7,
  parameter int RD_LATENCY = 1,
  parameter int AFULL_LVL  = 120,
  parameter int AEMPTY_LVL = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic              i_re,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic              o_ram_wen,
  output logic [ADDR_W-1:0] o_ram_raddr,
  output logic              o_ram_ren,
  output logic              o_dvld,
  output logic              o_full,
  output logic              o_afull,
  output logic              o_empty,
  output logic              o_aempty,
  output logic [ADDR_W:0]   o_wcnt,
  output logic              o_overflow,
  output logic              o_underflow
`ifdef LSRAM_FIFO_CTRL_ECC_EN
  ,
  input  logic              i_sb_correct,
  input  logic              i_db_detect,
  output logic [7:0]        o_sb_cnt,
  output logic              o_db_err
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  C_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_AFULL  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0]  C_AEMPTY = CNT_W'(AEMPTY_LVL);
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0]     r_wptr;
  logic [ADDR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [RD_LATENCY-1:0] r_rd_pipe;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [CNT_W-1:0]      w_cnt_nxt;

  // Accept decisions use the flags registered at the start of the cycle; reset blocks both.
  always_comb begin
    w_wr_ok = i_we & ~r_full  & ~i_reset;
    w_rd_ok = i_re & ~r_empty & ~i_reset;
  end

  // Next occupancy: simultaneous accepted read and write leave the count unchanged.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr_ok && !w_rd_ok) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (!w_wr_ok && w_rd_ok) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Pointers wrap by compare at DEPTH-1 so non-power-of-2 depths work.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= (r_wptr == C_LAST) ? '0 : r_wptr + ADDR_W'(1);
      if (w_rd_ok) r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + ADDR_W'(1);
    end
  end

  // Count and all status flags are registered from the next count so they move together.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_full      <= (w_cnt_nxt == C_DEPTH);
      r_afull     <= (w_cnt_nxt >= C_AFULL);
      r_empty     <= (w_cnt_nxt == '0);
      r_aempty    <= (w_cnt_nxt <= C_AEMPTY);
      r_overflow  <= i_we & r_full;
      r_underflow <= i_re & r_empty;
    end
  end

  // Read-data-valid pipeline; reset drops any reads still in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe <= (r_rd_pipe << 1) | RD_LATENCY'(w_rd_ok);
    end
  end

  assign o_ram_waddr = r_wptr;
  assign o_ram_wen   = w_wr_ok;
  assign o_ram_raddr = r_rptr;
  assign o_ram_ren   = w_rd_ok;
  assign o_dvld      = r_rd_pipe[RD_LATENCY-1];
  assign o_full      = r_full;
  assign o_afull     = r_afull;
  assign o_empty     = r_empty;
  assign o_aempty    = r_aempty;
  assign o_wcnt      = r_cnt;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

`ifdef LSRAM_FIFO_CTRL_ECC_EN
  logic [7:0] r_sb_cnt;
  logic       r_db_err;

  // Error indications are only meaningful alongside valid read data; counter saturates, DB is sticky.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sb_cnt <= '0;
      r_db_err <= 1'b0;
    end else if (o_dvld) begin
      if (i_sb_correct && (r_sb_cnt != 8'hFF)) r_sb_cnt <= r_sb_cnt + 8'd1;
      if (i_db_detect) r_db_err <= 1'b1;
    end
  end

  assign o_sb_cnt = r_sb_cnt;
  assign o_db_err = r_db_err;
`endif

endmodule

// File: tb/tb_lsram_fifo_ctrl.sv
// Bench for lsram_fifo_ctrl: table of single-cycle vectors plus hand-written fill/drain/wrap/reset sequences.
// DUT built with DEPTH=128, RD_LATENCY=2 so read-valid delay and in-flight reset are both exercised.
module tb_lsram_fifo_ctrl;

  localparam int ADDR_W = 7;

  logic              clk;
  logic              rst;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_ren;
  logic              dvld;
  logic              full;
  logic              afull;
  logic              empty;
  logic              aempty;
  logic [ADDR_W:0]   wcnt;
  logic              overflow;
  logic              underflow;
`ifdef LSRAM_FIFO_CTRL_ECC_EN
  logic              sb_correct;
  logic              db_detect;
  logic [7:0]        sb_cnt;
  logic              db_err;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  lsram_fifo_ctrl #(
    .DEPTH(128), .ADDR_W(ADDR_W), .RD_LATENCY(2), .AFULL_LVL(120), .AEMPTY_LVL(8)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_we(we), .i_re(re),
    .o_ram_waddr(ram_waddr), .o_ram_wen(ram_wen),
    .o_ram_raddr(ram_raddr), .o_ram_ren(ram_ren),
    .o_dvld(dvld), .o_full(full), .o_afull(afull),
    .o_empty(empty), .o_aempty(aempty), .o_wcnt(wcnt),
    .o_overflow(overflow), .o_underflow(underflow)
`ifdef LSRAM_FIFO_CTRL_ECC_EN
    , .i_sb_correct(sb_correct), .i_db_detect(db_detect),
    .o_sb_cnt(sb_cnt), .o_db_err(db_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, we, re;
    int   wcnt;
    logic empty, full, aempty, afull, ovf, udf, dvld;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic pf, pe;
    rst = 1'b1; we = 1'b0; re = 1'b0;
`ifdef LSRAM_FIFO_CTRL_ECC_EN
    sb_correct = 1'b0; db_detect = 1'b0;
`endif

    //          rst we re wcnt emp ful aem afu ovf udf dvld
    vt[0]  = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    vt[2]  = '{0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vt[3]  = '{0, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    vt[5]  = '{0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 1};
    vt[6]  = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1};
    vt[7]  = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1};
    vt[8]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    vt[9]  = '{0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0};
    vt[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};

    // Table: one vector per clock, strobes checked before the edge, registered state after it.
    pf = 1'b0; pe = 1'b1;
    for (int i = 0; i < 11; i++) begin
      rst = vt[i].rst; we = vt[i].we; re = vt[i].re;
      #1;
      if (i > 0) begin
        chk($sformatf("v%0d ram_wen", i), ram_wen, int'(vt[i].we & ~pf & ~vt[i].rst));
        chk($sformatf("v%0d ram_ren", i), ram_ren, int'(vt[i].re & ~pe & ~vt[i].rst));
      end
      step();
      chk($sformatf("v%0d wcnt", i),   wcnt,      vt[i].wcnt);
      chk($sformatf("v%0d empty", i),  empty,     vt[i].empty);
      chk($sformatf("v%0d full", i),   full,      vt[i].full);
      chk($sformatf("v%0d aempty", i), aempty,    vt[i].aempty);
      chk($sformatf("v%0d afull", i),  afull,     vt[i].afull);
      chk($sformatf("v%0d ovf", i),    overflow,  vt[i].ovf);
      chk($sformatf("v%0d udf", i),    underflow, vt[i].udf);
      chk($sformatf("v%0d dvld", i),   dvld,      vt[i].dvld);
      pf = vt[i].full; pe = vt[i].empty;
    end

    // Fill: 130 writes, the last two rejected.
    do_reset();
    for (int i = 1; i <= 130; i++) begin
      we = 1'b1;
      #1;
      chk($sformatf("fill%0d ram_wen", i), ram_wen, (i <= 128) ? 1 : 0);
      step();
      chk($sformatf("fill%0d wcnt", i),  wcnt,     (i <= 128) ? i : 128);
      chk($sformatf("fill%0d afull", i), afull,    (i >= 120) ? 1 : 0);
      chk($sformatf("fill%0d full", i),  full,     (i >= 128) ? 1 : 0);
      chk($sformatf("fill%0d ovf", i),   overflow, (i >= 129) ? 1 : 0);
      chk($sformatf("fill%0d waddr", i), ram_waddr, (i <= 127) ? i : 0);
    end
    we = 1'b0;

    // Drain: 129 reads, the last one rejected; DVLD trails accepted reads by 2 edges.
    for (int i = 0; i <= 128; i++) begin
      re = 1'b1;
      #1;
      chk($sformatf("drain%0d raddr", i), ram_raddr, (i < 128) ? i : 0);
      chk($sformatf("drain%0d ram_ren", i), ram_ren, (i < 128) ? 1 : 0);
      step();
      chk($sformatf("drain%0d dvld", i), dvld, (i >= 1 && i <= 128) ? 1 : 0);
      chk($sformatf("drain%0d udf", i), underflow, (i == 128) ? 1 : 0);
    end
    re = 1'b0;
    chk("drain empty", empty, 1);
    chk("drain wcnt", wcnt, 0);
    step();
    chk("drain tail dvld", dvld, 0);

    // Streaming at WCNT=5 for 200 cycles: count and flags constant, pointers wrap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      we = 1'b1;
      step();
    end
    re = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      chk($sformatf("stream%0d wcnt", i), wcnt, 5);
      chk($sformatf("stream%0d flags", i), {empty, aempty, afull, full, overflow, underflow}, 6'b010000);
    end
    we = 1'b0; re = 1'b0;
    chk("stream waddr", ram_waddr, 77);
    chk("stream raddr", ram_raddr, 72);

    // WE&RE while FULL: read only, overflow.
    do_reset();
    for (int i = 0; i < 128; i++) begin
      we = 1'b1;
      step();
    end
    re = 1'b1;
    step();
    chk("full_wr_rd wcnt", wcnt, 127);
    chk("full_wr_rd ovf", overflow, 1);
    chk("full_wr_rd full", full, 0);
    chk("full_wr_rd raddr", ram_raddr, 1);
    chk("full_wr_rd waddr", ram_waddr, 0);

    // WE&RE while EMPTY: write only, underflow.
    do_reset();
    we = 1'b1; re = 1'b1;
    step();
    chk("empty_wr_rd wcnt", wcnt, 1);
    chk("empty_wr_rd udf", underflow, 1);
    chk("empty_wr_rd empty", empty, 0);
    chk("empty_wr_rd raddr", ram_raddr, 0);
    we = 1'b0; re = 1'b0;

    // Reset with reads in flight: DVLD never rises, everything back to reset values.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      we = 1'b1;
      step();
    end
    we = 1'b0; re = 1'b1;
    step();
    rst = 1'b1;
    #1;
    chk("rst_flight ram_ren", ram_ren, 0);
    step();
    rst = 1'b0; re = 1'b0;
    chk("rst_flight dvld", dvld, 0);
    chk("rst_flight wcnt", wcnt, 0);
    chk("rst_flight state", {empty, aempty, full, afull, overflow, underflow}, 6'b110000);
    chk("rst_flight waddr", ram_waddr, 0);
    chk("rst_flight raddr", ram_raddr, 0);
    step();
    chk("rst_flight dvld+1", dvld, 0);
    step();
    chk("rst_flight dvld+2", dvld, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
